sync_fifo_ctl: RTL and testbench

Single-clock FIFO pointer and flag controller, the parametrised successor to the existing write-side pointer block. It owns both the write and read pointers of a 2^A_SIZE-entry FIFO and drives the external dual-port RAM's address and enable strobes. It reports full, empty, programmable almost-full/almost-empty watermarks, an exact fill level, and optional sticky overflow/underflow errors. It is used wherever producer and consumer share `wclk`, so no pointer synchroniser is needed.

---
 rtl/sync_fifo_ctl_if.sv | 33 +++
 rtl/sync_fifo_ctl.sv | 91 +++++++++
 tb/tb_sync_fifo_ctl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctl_if.sv
// Handshake and status bundle between a FIFO user (master) and sync_fifo_ctl (slave).
`timescale 1ns/1ps
interface sync_fifo_ctl_if #(
    parameter int A_SIZE = 4
);
    logic              wen;
    logic              ren;
    logic              err_clr;
    logic              mem_we;
    logic              mem_re;
    logic [A_SIZE-1:0] waddr;
    logic [A_SIZE-1:0] raddr;
    logic [A_SIZE:0]   wptr;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [A_SIZE:0]   level;
    logic              overflow;
    logic              underflow;

    modport master (
        output wen, ren, err_clr,
        input  mem_we, mem_re, waddr, raddr, wptr, full, empty,
               almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  wen, ren, err_clr,
        output mem_we, mem_re, waddr, raddr, wptr, full, empty,
               almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO pointer/flag controller. Sticky overflow/underflow error
// registers exist only when SYNC_FIFO_CTL_ERR_EN is defined.
`timescale 1ns/1ps
module sync_fifo_ctl #(
    parameter int A_SIZE    = 4,
    parameter int AF_THRESH = (1 << A_SIZE) - 2,
    parameter int AE_THRESH = 2
) (
    input logic            wclk,
    input logic            wrst,
    sync_fifo_ctl_if.slave bus
);
    localparam int PW = A_SIZE + 1;
    localparam logic [A_SIZE:0] DEPTH_L = PW'(1 << A_SIZE);
    localparam logic [A_SIZE:0] AF_L    = PW'(AF_THRESH);
    localparam logic [A_SIZE:0] AE_L    = PW'(AE_THRESH);

    logic [A_SIZE:0] wbin, rbin, wbin_n, rbin_n, lvl_n;
    logic [A_SIZE:0] wptr_q, level_q;
    logic            full_q, empty_q, af_q, ae_q;
    logic            wr_acc, rd_acc;

    // Accepts depend only on the registered flags, so the RAM strobes are glitch-safe.
    always_comb begin
        wr_acc = bus.wen & ~full_q;
        rd_acc = bus.ren & ~empty_q;
        wbin_n = wbin + PW'(wr_acc);
        rbin_n = rbin + PW'(rd_acc);
        lvl_n  = wbin_n - rbin_n;
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin    <= '0;
            rbin    <= '0;
            wptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            wbin    <= wbin_n;
            rbin    <= rbin_n;
            wptr_q  <= (wbin_n >> 1) ^ wbin_n;
            level_q <= lvl_n;
            full_q  <= (lvl_n == DEPTH_L);
            empty_q <= (lvl_n == '0);
            af_q    <= (lvl_n >= AF_L);
            ae_q    <= (lvl_n <= AE_L);
        end
    end

`ifdef SYNC_FIFO_CTL_ERR_EN
    logic ovf_q, udf_q;

    // A fresh error in the same cycle as err_clr takes priority over the clear.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.wen & full_q)
                ovf_q <= 1'b1;
            else if (bus.err_clr)
                ovf_q <= 1'b0;
            if (bus.ren & empty_q)
                udf_q <= 1'b1;
            else if (bus.err_clr)
                udf_q <= 1'b0;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.mem_we       = wr_acc;
    assign bus.mem_re       = rd_acc;
    assign bus.waddr        = wbin[A_SIZE-1:0];
    assign bus.raddr        = rbin[A_SIZE-1:0];
    assign bus.wptr         = wptr_q;
    assign bus.level        = level_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Self-checking bench for sync_fifo_ctl: directed corner cases plus random traffic
// against an occupancy-count reference model.
`timescale 1ns/1ps
module tb_sync_fifo_ctl;
    localparam int A_SIZE = 4;
    localparam int DEPTH  = 1 << A_SIZE;
    localparam int AF     = DEPTH - 2;
    localparam int AE     = 2;
`ifdef SYNC_FIFO_CTL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic wclk = 1'b0;
    logic wrst = 1'b1;

    sync_fifo_ctl_if #(.A_SIZE(A_SIZE)) bus ();

    sync_fifo_ctl #(
        .A_SIZE   (A_SIZE),
        .AF_THRESH(AF),
        .AE_THRESH(AE)
    ) dut (
        .wclk(wclk),
        .wrst(wrst),
        .bus (bus)
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;

    // Reference model: total accepted writes/reads since reset and the sticky errors.
    int wr_total = 0;
    int rd_total = 0;
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int gray(input int b);
        return (b >> 1) ^ b;
    endfunction

    task automatic checkAll();
        int lvl;
        lvl = wr_total - rd_total;
        checkOutput("level",        int'(bus.level),        lvl);
        checkOutput("full",         int'(bus.full),         int'(lvl == DEPTH));
        checkOutput("empty",        int'(bus.empty),        int'(lvl == 0));
        checkOutput("almost_full",  int'(bus.almost_full),  int'(lvl >= AF));
        checkOutput("almost_empty", int'(bus.almost_empty), int'(lvl <= AE));
        checkOutput("waddr",        int'(bus.waddr),        wr_total % DEPTH);
        checkOutput("raddr",        int'(bus.raddr),        rd_total % DEPTH);
        checkOutput("wptr",         int'(bus.wptr),         gray(wr_total % (2 * DEPTH)));
        checkOutput("overflow",     int'(bus.overflow),     int'(m_ovf));
        checkOutput("underflow",    int'(bus.underflow),    int'(m_udf));
    endtask

    // Drives one cycle, checks the RAM strobes before the edge and all state after it.
    task automatic applyStimulus(input bit w, input bit r, input bit c, input bit rs);
        int  lvl;
        bit  wa, ra;
        bus.wen     = w;
        bus.ren     = r;
        bus.err_clr = c;
        wrst        = rs;
        #1;
        lvl = wr_total - rd_total;
        wa  = w && (lvl != DEPTH);
        ra  = r && (lvl != 0);
        if (!rs) begin
            checkOutput("mem_we", int'(bus.mem_we), int'(wa));
            checkOutput("mem_re", int'(bus.mem_re), int'(ra));
        end
        @(posedge wclk);
        #1;
        if (rs) begin
            wr_total = 0;
            rd_total = 0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
        end else begin
            if (ERR_EN) begin
                if (w && lvl == DEPTH) m_ovf = 1'b1;
                else if (c)            m_ovf = 1'b0;
                if (r && lvl == 0)     m_udf = 1'b1;
                else if (c)            m_udf = 1'b0;
            end
            wr_total += int'(wa);
            rd_total += int'(ra);
        end
        checkAll();
    endtask

    initial begin
        bus.wen     = 1'b0;
        bus.ren     = 1'b0;
        bus.err_clr = 1'b0;
        @(posedge wclk);
        #1;

        $display("[TB] reset");
        applyStimulus(0, 0, 0, 1);

        $display("[TB] fill to full");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 0);

        $display("[TB] simultaneous read/write at full");
        applyStimulus(1, 1, 0, 0);
        checkOutput("level_after_full_rw", int'(bus.level), DEPTH - 1);

        $display("[TB] drain, then simultaneous read/write at empty");
        while (wr_total != rd_total) applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("level_after_empty_rw", int'(bus.level), 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 100; i++)
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                          $urandom_range(0, 9) == 0, 0);
        for (int i = 0; i < 80; i++)
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 0);

        $display("[TB] error flags");
        while (wr_total - rd_total != DEPTH) applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("overflow_at_full", int'(bus.overflow), int'(ERR_EN));
        while (wr_total != rd_total) applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0);
        checkOutput("underflow_with_clr", int'(bus.underflow), int'(ERR_EN));
        checkOutput("overflow_cleared", int'(bus.overflow), 0);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 1);
        checkOutput("level_after_rst", int'(bus.level), 0);
        applyStimulus(1, 0, 0, 0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
